f1_light_seq: RTL and testbench

- F1-style start-light sequencer and reaction timer.
- Sits directly downstream of the programmable clock-tick divider: consumes its one-cycle `tick` pulse and drives the divider's enable.
- Fills an 8-light bar one light per tick, holds all lights on for a pseudo-random number of ticks, then turns them off.
- Measures player reaction in clk cycles from lights-out to the `react` input.

---
 rtl/f1_light_seq.sv | 142 ++++++++++++++
 tb/tb_f1_light_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/f1_light_seq.sv
// rtl/f1_light_seq.sv - F1-style start-light sequencer and reaction timer
//
// Fills an LIGHTS-wide light bar one light per upstream tick, holds all
// lights for a pseudo-random number of ticks (taken from a free-running
// LFSR), turns them off and then counts clk cycles until the player reacts.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   trigger      start request, rising edge starts a sequence from IDLE
//   tick         one-cycle pulse from the upstream tick divider
//   react        player button, level, synchronous to clk
//   tick_en      divider enable, high while filling or holding
//   data_out     light bar, bit 0 = first light
//   rt_cycles    last measured reaction time in clk cycles
//   rt_valid     one-cycle pulse when rt_cycles is updated
//   false_start  one-cycle pulse when react arrives before lights-out
//   busy         high whenever a sequence is in progress
module f1_light_seq #(
  parameter int LIGHTS     = 8,
  parameter int LFSR_WIDTH = 7,
  parameter int RT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                tick,
  input  logic                react,
  output logic                tick_en,
  output logic [LIGHTS-1:0]   data_out,
  output logic [RT_WIDTH-1:0] rt_cycles,
  output logic                rt_valid,
  output logic                false_start,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] delay_cnt, delay_nx;
  logic [LIGHTS-1:0]     data_nx;
  logic [RT_WIDTH-1:0]   rt_cnt, rt_cnt_nx, rt_cycles_nx;
  logic                  rt_valid_nx, false_start_nx;
  logic                  trig_q, trig_edge, fill_last;

  assign trig_edge = trigger & ~trig_q;
  // All lower lights lit: the next tick completes the bar.
  assign fill_last = &data_out[LIGHTS-2:0];

  assign tick_en = (state == FILL) || (state == HOLD);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= LFSR_WIDTH'(1);
      trig_q      <= 1'b0;
      delay_cnt   <= '0;
      rt_cnt      <= '0;
      data_out    <= '0;
      rt_cycles   <= '0;
      rt_valid    <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= state_nx;
      // x^7 + x^3 + 1, free-running in every state so the hold delay
      // depends on when the player pressed trigger.
      lfsr        <= {lfsr[LFSR_WIDTH-2:0], lfsr[LFSR_WIDTH-1] ^ lfsr[2]};
      trig_q      <= trigger;
      delay_cnt   <= delay_nx;
      rt_cnt      <= rt_cnt_nx;
      data_out    <= data_nx;
      rt_cycles   <= rt_cycles_nx;
      rt_valid    <= rt_valid_nx;
      false_start <= false_start_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    data_nx        = data_out;
    delay_nx       = delay_cnt;
    rt_cnt_nx      = rt_cnt;
    rt_cycles_nx   = rt_cycles;
    rt_valid_nx    = 1'b0;
    false_start_nx = 1'b0;
    case (state)
      IDLE: begin
        if (trig_edge) begin
          state_nx = FILL;
          data_nx  = '0;
        end
      end
      FILL: begin
        // A press before lights-out wins over any coincident tick.
        if (react) begin
          data_nx        = '0;
          false_start_nx = 1'b1;
          state_nx       = IDLE;
        end else if (tick) begin
          data_nx = {data_out[LIGHTS-2:0], 1'b1};
          if (fill_last) begin
            delay_nx = lfsr;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (react) begin
          data_nx        = '0;
          false_start_nx = 1'b1;
          state_nx       = IDLE;
        end else if (tick) begin
          if (delay_cnt == LFSR_WIDTH'(1)) begin
            data_nx   = '0;
            rt_cnt_nx = '0;
            state_nx  = OUT;
          end else begin
            delay_nx = delay_cnt - 1'b1;
          end
        end
      end
      OUT: begin
        if (react) begin
          rt_cycles_nx = rt_cnt;
          rt_valid_nx  = 1'b1;
          state_nx     = IDLE;
        end else if (~&rt_cnt) begin
          rt_cnt_nx = rt_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_f1_light_seq.sv
// tb/tb_f1_light_seq.sv - randomized self-checking bench for f1_light_seq
module tb_f1_light_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic        react = 1'b0;
  logic        tick_man = 1'b0;
  logic        div_mode = 1'b0;
  logic        div_tick = 1'b0;
  logic        tick;
  logic        tick_en;
  logic [7:0]  data_out;
  logic [15:0] rt_cycles;
  logic        rt_valid;
  logic        false_start;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ecount;
  int div_cnt  = 0;
  int exp_rt   = 0;
  logic [6:0] lseq [127];

  assign tick = div_mode ? div_tick : tick_man;

  f1_light_seq dut (
    .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .react(react),
    .tick_en(tick_en), .data_out(data_out), .rt_cycles(rt_cycles),
    .rt_valid(rt_valid), .false_start(false_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the LFSR value seen at edge k is lseq[(k-1)%127].
  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  // Behavioural divide-by-4 tick source, held in reset while not enabled.
  always @(negedge clk) begin
    if (!div_mode || !tick_en) begin
      div_cnt  = 0;
      div_tick = 1'b0;
    end else begin
      div_tick = (div_cnt == 3);
      div_cnt  = (div_cnt == 3) ? 0 : div_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_tick_en"}, 32'(tick_en), 32'h0);
  endtask

  // Start a sequence with tick tied high and verify the bar fills one light
  // per edge; returns the hold length the model predicts.
  task automatic run_fill(output int d);
    int k;
    tick_man = 1'b1;
    trigger  = 1'b1;
    step();
    trigger = 1'b0;
    check("entry_data", 32'(data_out), 32'h0);
    check("entry_busy", 32'(busy), 32'h1);
    check("entry_tick_en", 32'(tick_en), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("fill_data", 32'(data_out), (32'h2 << i) - 32'h1);
    end
    k = ecount;
    d = int'(lseq[(k - 1) % 127]);
  endtask

  task automatic run_hold(input int d);
    for (int i = 1; i < d; i++) begin
      step();
      check("hold_data", 32'(data_out), 32'hff);
      check("hold_tick_en", 32'(tick_en), 32'h1);
    end
    step();
    check("out_data", 32'(data_out), 32'h0);
    check("out_tick_en", 32'(tick_en), 32'h0);
    check("out_busy", 32'(busy), 32'h1);
  endtask

  task automatic react_after(input int r);
    for (int i = 0; i < r; i++) step();
    react = 1'b1;
    step();
    react = 1'b0;
    exp_rt = r;
    check("rt_cycles", 32'(rt_cycles), 32'(r));
    check("rt_valid", 32'(rt_valid), 32'h1);
    check("rt_busy", 32'(busy), 32'h0);
    step();
    check("rt_valid_pulse", 32'(rt_valid), 32'h0);
  endtask

  task automatic false_start_now(input string tag);
    react = 1'b1;
    step();
    react = 1'b0;
    check({tag, "_fs"}, 32'(false_start), 32'h1);
    check({tag, "_data"}, 32'(data_out), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_rt_keep"}, 32'(rt_cycles), 32'(exp_rt));
    step();
    check({tag, "_fs_pulse"}, 32'(false_start), 32'h0);
  endtask

  initial begin
    int d, fill_cyc, starts, found, r, j;
    logic [6:0] q;
    logic [7:0] prev;
    q = 7'h01;
    for (int i = 0; i < 127; i++) begin
      lseq[i] = q;
      q = {q[5:0], q[6] ^ q[2]};
    end

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rt", 32'(rt_cycles), 32'h0);
    check("reset_rt_valid", 32'(rt_valid), 32'h0);
    check("reset_fs", 32'(false_start), 32'h0);
    rst = 1'b0;
    step();

    // Full sequence with tick tied high, then a 37-cycle reaction
    run_fill(d);
    run_hold(d);
    react_after(37);

    // False start at 07
    step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (3) step();
    check("fs_fill_data", 32'(data_out), 32'h07);
    false_start_now("fs_fill");

    // False start coinciding with the final HOLD tick
    run_fill(d);
    for (int i = 1; i < d; i++) step();
    false_start_now("fs_last_tick");

    // Divide-by-4 ticks, trigger held high for 50 cycles
    div_mode = 1'b1;
    trigger  = 1'b1;
    fill_cyc = -1;
    starts   = 0;
    prev     = data_out;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (prev == 8'h00 && data_out == 8'h01) starts++;
      if (data_out == 8'hff && fill_cyc < 0) fill_cyc = c - 1;
      prev = data_out;
    end
    trigger = 1'b0;
    check("div_fill_cycles", 32'(fill_cyc), 32'd32);
    check("div_single_start", 32'(starts), 32'd1);
    found = 0;
    for (int c = 0; c < 600 && found == 0; c++) begin
      if (busy && !tick_en) found = 1;
      else step();
    end
    check("div_reach_out", 32'(found), 32'h1);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (3) step();
    check("second_edge_busy", 32'(busy), 32'h1);
    check("second_edge_tick_en", 32'(tick_en), 32'h0);
    check("second_edge_data", 32'(data_out), 32'h0);
    react = 1'b1;
    step();
    react = 1'b0;
    check("div_rt_valid", 32'(rt_valid), 32'h1);
    exp_rt = int'(rt_cycles);
    div_mode = 1'b0;
    step();

    // Randomized sequences: reaction after a random delay or a random false start
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(1, 5)) step();
      run_fill(d);
      if ($urandom_range(0, 1) == 0) begin
        run_hold(d);
        r = $urandom_range(0, 40);
        react_after(r);
      end else begin
        j = $urandom_range(0, d - 1);
        for (int i = 0; i < j; i++) step();
        false_start_now("fs_rand");
      end
    end

    // Asynchronous reset mid-HOLD, then the LFSR restarts from its seed
    step();
    run_fill(d);
    check("pre_reset_data", 32'(data_out), 32'hff);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_rt", 32'(rt_cycles), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_fill(d);
    check("seed1_d", 32'(d), 32'(lseq[8]));
    run_hold(d);
    react_after($urandom_range(0, 20));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
